// File: rtl/sseg_pkg.sv
// sseg_pkg: character encoding and hex-to-segment glyphs for the scroller
package sseg_pkg;
    localparam logic [5:0] CHAR_BLANK = 6'b100000;
    localparam int BLANK_BIT = 5;
    localparam int DP_BIT = 4;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction
    function automatic logic [7:0] char_seg(input logic [5:0] c);
        return c[BLANK_BIT] ? SEG_OFF : {~c[DP_BIT], glyph(c[3:0])};
    endfunction
endpackage

// File: rtl/sseg_scroller_if.sv
// sseg_scroller_if: message write, scroll control and display pins
interface sseg_scroller_if #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN = 16
);
    localparam int AW = $clog2(MSG_LEN);
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0] wr_data;
    logic run;
    logic dir;
    logic step;
    logic [7:0] sseg;
    logic [NUM_DIGITS-1:0] en;
    logic [AW-1:0] offset;
    logic wrap;
    modport master (output wr_en, wr_addr, wr_data, run, dir, step, input sseg, en, offset, wrap);
    modport slave (input wr_en, wr_addr, wr_data, run, dir, step, output sseg, en, offset, wrap);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: one-cycle clock-enable pulse every DIV clk cycles
module tick_gen #(
    parameter int DIV = 2
) (
    input logic clk,
    input logic rst,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick = cnt_q == CW'(DIV - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sseg_scroller.sv
// sseg_scroller: multiplexed seven-segment driver scrolling a message buffer
module sseg_scroller
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN = 16,
    parameter int REFRESH_DIV = 49000,
    parameter int SCROLL_DIV = 25000000
) (
    input logic clk,
    input logic rst,
    sseg_scroller_if.slave bus
);
    localparam int AW = $clog2(MSG_LEN);
    logic rtick, stick, adv;
    logic [AW-1:0] k_q, k_d, offset_q, offset_d;
    logic wrap_q, wrap_d;
    logic [7:0] sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [5:0] buf_q [MSG_LEN];
    logic [5:0] buf_d [MSG_LEN];
    logic [AW:0] sum, idx;
    tick_gen #(.DIV(REFRESH_DIV)) u_refresh (.clk(clk), .rst(rst), .tick(rtick));
    tick_gen #(.DIV(SCROLL_DIV)) u_scroll (.clk(clk), .rst(rst), .tick(stick));
    // Refresh reads buf_q and offset_q, so same-cycle writes and advances show up one refresh later
    always_comb begin
        k_d = !rtick ? k_q : k_q == AW'(NUM_DIGITS - 1) ? '0 : k_q + 1'b1;
        sum = {1'b0, offset_q} + {1'b0, k_d};
        idx = sum >= (AW+1)'(MSG_LEN) ? sum - (AW+1)'(MSG_LEN) : sum;
        sseg_d = rtick ? char_seg(buf_q[idx[AW-1:0]]) : sseg_q;
        en_d = rtick ? ~(NUM_DIGITS'(1) << k_d) : en_q;
        adv = bus.run ? stick : bus.step;
        wrap_d = adv && (bus.dir ? offset_q == '0 : offset_q == AW'(MSG_LEN - 1));
        offset_d = !adv ? offset_q : wrap_d ? (bus.dir ? AW'(MSG_LEN - 1) : '0) :
                   bus.dir ? offset_q - 1'b1 : offset_q + 1'b1;
        buf_d = buf_q;
        if (bus.wr_en && {1'b0, bus.wr_addr} < (AW+1)'(MSG_LEN)) buf_d[bus.wr_addr] = bus.wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            offset_q <= '0;
            wrap_q <= 1'b0;
            sseg_q <= SEG_OFF;
            en_q <= '1;
            for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= CHAR_BLANK;
        end else begin
            k_q <= k_d;
            offset_q <= offset_d;
            wrap_q <= wrap_d;
            sseg_q <= sseg_d;
            en_q <= en_d;
            buf_q <= buf_d;
        end
    end
    assign bus.sseg = sseg_q;
    assign bus.en = en_q;
    assign bus.offset = offset_q;
    assign bus.wrap = wrap_q;
endmodule
